// File: rtl/decode_in_fetch_pkg.sv
// Shared types and constants for the decode-stage fetch/issue block.
package decode_in_fetch_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h3000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_issue_queue.sv
// Two-entry shift FIFO of fetched instructions; entry 0 is always the head so
// the decode-facing outputs come straight from a register.
module fetch_issue_queue
    import decode_in_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_entry_i;
                    end else begin
                        tail_d = push_entry_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_d = push_entry_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/decode_in_fetch_issue.sv
// LC3 fetch/issue: owns the PC, issues single-cycle imem reads and feeds decode
// from a 2-entry queue, with back-pressure and branch redirect.
module decode_in_fetch_issue
    import decode_in_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_dout,
    output logic [15:0] Instr_dout,
    output logic [15:0] npc_in,
    output logic        enable_decode
);

    logic [15:0]  pc_q, pc_d;
    logic         inflight_q;
    logic [15:0]  inflight_addr_q;
    logic [1:0]   count;
    logic         pop, push, issue;
    logic [2:0]   occupancy, limit;
    fetch_entry_t push_entry, head;

    always_comb begin
        pop              = (count != 2'd0) && !stall && !br_taken;
        push             = inflight_q && !br_taken;
        push_entry.instr = imem_dout;
        push_entry.npc   = inflight_addr_q + 16'd1;
        // Reserve a slot for every word in flight so a return can never overflow.
        occupancy        = {1'b0, count} + {2'b00, inflight_q};
        limit            = 3'(DEPTH) + {2'b00, pop};
        issue            = !reset && !br_taken && (occupancy < limit);
        pc_d             = pc_q;
        if (br_taken) begin
            pc_d = taddr;
        end else if (issue) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q <= pc_q;
            end
        end
    end

    fetch_issue_queue u_queue (
        .clk_i        (clock),
        .rst_i        (reset),
        .flush_i      (br_taken),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .count_o      (count),
        .head_o       (head)
    );

    assign imem_rd       = issue;
    assign imem_addr     = pc_q;
    assign Instr_dout    = head.instr;
    assign npc_in        = head.npc;
    assign enable_decode = (count != 2'd0);

endmodule

// File: tb/tb_decode_in_fetch_issue.sv
// Self-checking bench: memory model mem[A]=A^5A5A, scoreboard of expected
// {instr, npc} pushed on each issue and popped on each decode handshake.
module tb_decode_in_fetch_issue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] taddr = 16'h0000;
    logic [15:0] imem_dout = 16'h0000;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] Instr_dout;
    logic [15:0] npc_in;
    logic        enable_decode;

    always #5 clock = ~clock;

    decode_in_fetch_issue dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .br_taken      (br_taken),
        .taddr         (taddr),
        .imem_rd       (imem_rd),
        .imem_addr     (imem_addr),
        .imem_dout     (imem_dout),
        .Instr_dout    (Instr_dout),
        .npc_in        (npc_in),
        .enable_decode (enable_decode)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic        last_rd = 1'b0;
    logic [15:0] last_addr = 16'h0000;
    logic [15:0] exp_issue = 16'h3000;
    logic [15:0] hold_instr, hold_npc;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, settle, run the scoreboard.
    task automatic cyc(input logic st, input logic br, input logic [15:0] ta, input logic rs);
        exp_t e;
        @(negedge clock);
        stall     = st;
        br_taken  = br;
        taddr     = ta;
        reset     = rs;
        imem_dout = last_rd ? memf(last_addr) : 16'hBEEF;
        #1;
        if (rs || br) begin
            sb.delete();
            exp_issue = rs ? 16'h3000 : ta;
            if (!rs) check_eq("rd_on_redirect", 32'(imem_rd), 32'd0);
        end else begin
            if (enable_decode && !st) begin
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("sb_instr", 32'(Instr_dout), 32'(e.instr));
                    check_eq("sb_npc", 32'(npc_in), 32'(e.npc));
                end
            end
            if (imem_rd) begin
                check_eq("issue_addr", 32'(imem_addr), 32'(exp_issue));
                e.instr = memf(exp_issue);
                e.npc   = exp_issue + 16'd1;
                sb.push_back(e);
                exp_issue = exp_issue + 16'd1;
            end
        end
        last_rd   = imem_rd;
        last_addr = imem_addr;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        check_eq("rst_rd", 32'(imem_rd), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'h3000);
        check_eq("rst_en", 32'(enable_decode), 32'd0);
        check_eq("rst_instr", 32'(Instr_dout), 32'h0);
        check_eq("rst_npc", 32'(npc_in), 32'h0);

        // First fetch latency
        run(1);
        check_eq("c1_rd", 32'(imem_rd), 32'd1);
        check_eq("c1_addr", 32'(imem_addr), 32'h3000);
        check_eq("c1_en", 32'(enable_decode), 32'd0);
        run(1);
        check_eq("c2_en", 32'(enable_decode), 32'd0);
        run(1);
        check_eq("c3_en", 32'(enable_decode), 32'd1);
        check_eq("c3_instr", 32'(Instr_dout), 32'h6A5A);
        check_eq("c3_npc", 32'(npc_in), 32'h3001);
        for (int i = 0; i < 6; i++) begin
            run(1);
            check_eq("stream_en", 32'(enable_decode), 32'd1);
            check_eq("stream_rd", 32'(imem_rd), 32'd1);
        end

        // Stall for 5 cycles: outputs hold, issue stops once queue is full
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        hold_instr = Instr_dout;
        hold_npc   = npc_in;
        check_eq("stall_en", 32'(enable_decode), 32'd1);
        check_eq("stall_rd", 32'(imem_rd), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0);
            check_eq("stall_instr", 32'(Instr_dout), 32'(hold_instr));
            check_eq("stall_npc", 32'(npc_in), 32'(hold_npc));
            check_eq("stall_en", 32'(enable_decode), 32'd1);
            check_eq("stall_rd", 32'(imem_rd), 32'd0);
        end
        run(1);
        check_eq("release_instr", 32'(Instr_dout), 32'(hold_instr));
        check_eq("release_rd", 32'(imem_rd), 32'd1);
        for (int i = 0; i < 3; i++) begin
            run(1);
            check_eq("release_en", 32'(enable_decode), 32'd1);
        end

        // Redirect from steady stream
        cyc(1'b0, 1'b1, 16'h4000, 1'b0);
        run(1);
        check_eq("br_en_r1", 32'(enable_decode), 32'd0);
        check_eq("br_rd_r1", 32'(imem_rd), 32'd1);
        check_eq("br_addr_r1", 32'(imem_addr), 32'h4000);
        run(1);
        check_eq("br_en_r2", 32'(enable_decode), 32'd0);
        run(1);
        check_eq("br_en_r3", 32'(enable_decode), 32'd1);
        check_eq("br_instr_r3", 32'(Instr_dout), 32'h1A5A);
        check_eq("br_npc_r3", 32'(npc_in), 32'h4001);
        run(3);

        // Redirect and stall together: flush wins
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b1, 16'h5000, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("brst_en_r1", 32'(enable_decode), 32'd0);
        run(1);
        check_eq("brst_en_r2", 32'(enable_decode), 32'd0);
        run(1);
        check_eq("brst_en_r3", 32'(enable_decode), 32'd1);
        check_eq("brst_npc_r3", 32'(npc_in), 32'h5001);
        run(2);

        // PC wrap
        cyc(1'b0, 1'b1, 16'hFFFE, 1'b0);
        run(3);
        check_eq("wrap_instr0", 32'(Instr_dout), 32'hA5A4);
        check_eq("wrap_npc0", 32'(npc_in), 32'hFFFF);
        run(1);
        check_eq("wrap_npc1", 32'(npc_in), 32'h0000);
        run(1);
        check_eq("wrap_npc2", 32'(npc_in), 32'h0001);
        run(2);

        // Reset mid-stream: stale return dropped, fetch restarts at 3000
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        run(1);
        check_eq("mrst_en", 32'(enable_decode), 32'd0);
        check_eq("mrst_instr", 32'(Instr_dout), 32'h0);
        check_eq("mrst_npc", 32'(npc_in), 32'h0);
        check_eq("mrst_rd", 32'(imem_rd), 32'd1);
        check_eq("mrst_addr", 32'(imem_addr), 32'h3000);
        run(1);
        check_eq("mrst_en2", 32'(enable_decode), 32'd0);
        run(1);
        check_eq("mrst_en3", 32'(enable_decode), 32'd1);
        check_eq("mrst_instr3", 32'(Instr_dout), 32'h6A5A);
        check_eq("mrst_npc3", 32'(npc_in), 32'h3001);
        run(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
